// File: rtl/parity_sweep_checker_pkg.sv
// Shared encodings for the parity sweep checker: golden-mode codes, FSM states
// and the hold-counter width helper.
package parity_sweep_pkg;

  localparam logic [1:0] MODE_XOR  = 2'b00;
  localparam logic [1:0] MODE_XNOR = 2'b01;
  localparam logic [1:0] MODE_AND  = 2'b10;
  localparam logic [1:0] MODE_OR   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Hold counter only needs to reach HOLD_CYCLES-1; keep at least one bit.
  function automatic int hold_w(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/parity_sweep_checker_golden.sv
// Reference response of an ideal N-input gate for the selected golden mode.
module sweep_golden_model
  import parity_sweep_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [1:0]      mode,
  input  logic [N_IN-1:0] vec,
  output logic            expected
);

  always_comb begin
    expected = 1'b0;
    case (mode)
      MODE_XOR:  expected = ^vec;
      MODE_XNOR: expected = ~^vec;
      MODE_AND:  expected = &vec;
      MODE_OR:   expected = |vec;
      default:   expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/parity_sweep_checker.sv
// Exhaustive stimulus/compare engine for an N-input combinational gate.
// Define PARITY_SWEEP_GRAY_EN to walk vectors in reflected Gray order.
module parity_sweep_checker
  import parity_sweep_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [N_IN-1:0]  stim,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_vec,
  output logic [1:0]       dbg_state
);

  localparam int HW = hold_w(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  // start is a one-cycle request with no ready: it is accepted only in IDLE or
  // DONE and silently dropped while a sweep is running.
  state_t           state;
  logic [1:0]       mode_q;
  logic [HW-1:0]    hold_cnt;
  logic [N_IN-1:0]  cnt;
  logic [N_IN-1:0]  cnt_inc;
  logic             expected;
  logic             mismatch;
  logic             last_vec;
  logic [ERR_W-1:0] err_next;

  function automatic logic [N_IN-1:0] order(input logic [N_IN-1:0] c);
`ifdef PARITY_SWEEP_GRAY_EN
    return c ^ (c >> 1);
`else
    return c;
`endif
  endfunction

  sweep_golden_model #(.N_IN(N_IN)) u_golden (
    .mode     (mode_q),
    .vec      (stim),
    .expected (expected)
  );

  assign cnt_inc   = cnt + N_IN'(1);
  assign mismatch  = (dut_out != expected);
  assign last_vec  = &cnt;
  assign err_next  = (mismatch && (err_cnt != {ERR_W{1'b1}})) ? err_cnt + ERR_W'(1) : err_cnt;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      mode_q          <= MODE_XOR;
      hold_cnt        <= '0;
      cnt             <= '0;
      stim            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mode_q          <= mode;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            cnt             <= '0;
            stim            <= '0;
            hold_cnt        <= '0;
            busy            <= 1'b1;
            state           <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (hold_cnt == HOLD_LAST) begin
            err_cnt <= err_next;
            if (mismatch && !first_err_valid) begin
              first_err_vec   <= stim;
              first_err_valid <= 1'b1;
            end
            if (last_vec) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              state <= ST_DONE;
            end else begin
              cnt      <= cnt_inc;
              stim     <= order(cnt_inc);
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_sweep_checker.sv
// Bench for parity_sweep_checker: table-driven sweeps with a result scoreboard,
// plus reset-mid-sweep and counter-saturation sequences.
module tb_parity_sweep_checker;

  localparam logic [1:0] M_XOR = 2'b00, M_XNOR = 2'b01, M_AND = 2'b10, M_OR = 2'b11;
  localparam int K_XNOR = 0, K_STUCK0 = 1, K_OR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] stim;
  logic       dut_out;
  logic       busy, done, pass, first_err_valid;
  logic [7:0] err_cnt;
  logic [2:0] first_err_vec;
  logic [1:0] dbg_state;
  int         kind = K_XNOR;

  logic       start6 = 1'b0;
  logic [1:0] mode6 = 2'b00;
  logic [5:0] stim6;
  logic       dut_out6;
  logic       busy6, done6, pass6, fev_valid6;
  logic [3:0] err_cnt6;
  logic [5:0] fev6;
  logic [1:0] dbg_state6;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard entry: {pass, first_err_valid, first_err_vec[2:0], err_cnt[7:0]}
  logic [12:0] exp_q[$];

  typedef struct {
    logic [1:0] mode;
    int         kind;
    logic [7:0] err;
    logic       fvalid;
    logic [2:0] fev;
    logic       pass;
  } vec_t;
  vec_t tbl[6];
  logic [2:0] seq[8];

  always #5 clk = ~clk;

  parity_sweep_checker #(.N_IN(3), .HOLD_CYCLES(4), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .stim(stim),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec),
    .dbg_state(dbg_state)
  );

  parity_sweep_checker #(.N_IN(6), .HOLD_CYCLES(4), .ERR_W(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .mode(mode6), .stim(stim6),
    .dut_out(dut_out6), .busy(busy6), .done(done6), .pass(pass6), .err_cnt(err_cnt6),
    .first_err_valid(fev_valid6), .first_err_vec(fev6),
    .dbg_state(dbg_state6)
  );

  // Emulated gates under test.
  always_comb begin
    dut_out = 1'b0;
    case (kind)
      K_XNOR:   dut_out = ~^stim;
      K_STUCK0: dut_out = 1'b0;
      K_OR:     dut_out = |stim;
      default:  dut_out = 1'b0;
    endcase
  end
  assign dut_out6 = |stim6;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input logic [1:0] m, input int k, input logic [12:0] exp_res);
    int cyc;
    logic [12:0] e;
    @(negedge clk);
    mode  = m;
    kind  = k;
    start = 1'b1;
    exp_q.push_back(exp_res);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      if (cyc < 32) check("stim_seq", stim, seq[cyc/4]);
      if (cyc == 5)  mode = ~m;
      if (cyc == 12) start = 1'b1;
      if (cyc == 13) start = 1'b0;
      if (cyc == 31) start = 1'b1;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    mode  = m;
    check("busy_cycles", cyc, 32);
    check("done_set", done, 1'b1);
    check("state_done", dbg_state, 2'd2);
    if (exp_q.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("err_cnt", err_cnt, e[7:0]);
      check("first_err_vec", first_err_vec, e[10:8]);
      check("first_err_valid", first_err_valid, e[11]);
      check("pass", pass, e[12]);
    end
    @(negedge clk);
    check("done_held", done, 1'b1);
    check("busy_low", busy, 1'b0);
    check("stim_last", stim, seq[7]);
  endtask

  initial begin
    int cyc;
`ifdef PARITY_SWEEP_GRAY_EN
    seq[0] = 3'b000; seq[1] = 3'b001; seq[2] = 3'b011; seq[3] = 3'b010;
    seq[4] = 3'b110; seq[5] = 3'b111; seq[6] = 3'b101; seq[7] = 3'b100;
`else
    for (int i = 0; i < 8; i++) seq[i] = 3'(i);
`endif
    tbl[0] = '{M_XNOR, K_XNOR,   8'd0, 1'b0, 3'd0, 1'b1};
    tbl[1] = '{M_XNOR, K_STUCK0, 8'd4, 1'b1, 3'd0, 1'b0};
    tbl[2] = '{M_XOR,  K_XNOR,   8'd8, 1'b1, 3'd0, 1'b0};
    tbl[3] = '{M_XNOR, K_XNOR,   8'd0, 1'b0, 3'd0, 1'b1};
    tbl[4] = '{M_AND,  K_XNOR,   8'd5, 1'b1, 3'd0, 1'b0};
    tbl[5] = '{M_OR,   K_STUCK0, 8'd7, 1'b1, 3'd1, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_stim", stim, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_fvalid", first_err_valid, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++)
      run_sweep(tbl[i].mode, tbl[i].kind,
                {tbl[i].pass, tbl[i].fvalid, tbl[i].fev, tbl[i].err});

    // Reset in the middle of a sweep, with a start pulse while reset is held.
    @(negedge clk);
    mode = M_XNOR; kind = K_STUCK0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 0; cyc < 10; cyc++) @(negedge clk);
    check("mid_err", err_cnt, 1);
    check("mid_fvalid", first_err_valid, 1);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_stim", stim, 0);
    check("async_err", err_cnt, 0);
    check("async_done", done, 0);
    check("async_pass", pass, 0);
    check("async_fvalid", first_err_valid, 0);
    check("async_fev", first_err_vec, 0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_start_ignored", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", busy, 0);
    check("idle_state", dbg_state, 0);

    for (int i = 3; i < 6; i++)
      run_sweep(tbl[i].mode, tbl[i].kind,
                {tbl[i].pass, tbl[i].fvalid, tbl[i].fev, tbl[i].err});
    check("sb_drained", exp_q.size(), 0);

    // Wide instance: AND golden against an OR gate saturates a 4-bit counter.
    @(negedge clk);
    mode6 = M_AND; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    cyc = 0;
    while (busy6 && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    check("w_busy_cycles", cyc, 256);
    check("w_done", done6, 1);
    check("w_err_sat", err_cnt6, 4'hf);
    check("w_pass", pass6, 0);
    check("w_fvalid", fev_valid6, 1);
    check("w_fev", fev6, 6'b000001);
`ifdef PARITY_SWEEP_GRAY_EN
    check("w_stim_last", stim6, 6'b100000);
`else
    check("w_stim_last", stim6, 6'b111111);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
